// File: rtl/cam_pixel_capture_pkg.sv
`default_nettype none
// ============================================================================
// Module   : cam_pixel_capture_pkg
// Brief    : Shared types and defaults for the camera pixel capture block:
//            capture FSM states, RGB565 pixel layout, default frame geometry
//            and frame-buffer address width.
// Revision : 1.0 - initial release
// ============================================================================
package cam_pixel_capture_pkg;

    // Default stored frame geometry (QVGA)
    localparam int DEF_H_ACTIVE = 320;
    localparam int DEF_V_ACTIVE = 240;

    // Frame-buffer address width; 2^17 covers 320*240 = 76800 pixels
    localparam int FB_ADDR_W = 17;

    // Capture controller states
    typedef enum logic [1:0] {
        ST_IDLE       = 2'd0,
        ST_WAIT_VSYNC = 2'd1,
        ST_CAPTURE    = 2'd2
    } cap_state_t;

    // RGB565 pixel as delivered to the frame buffer (first camera byte on top)
    typedef struct packed {
        logic [4:0] red;
        logic [5:0] green;
        logic [4:0] blue;
    } rgb565_t;

endpackage
`default_nettype wire

// File: rtl/cam_sync_edge.sv
`default_nettype none
// ============================================================================
// Module   : cam_sync_edge
// Brief    : Single-bit SYNC_STAGES-deep synchroniser followed by a rising /
//            falling edge detector on the synchronised value.
// Revision : 1.0 - initial release
// ============================================================================
module cam_sync_edge
    import cam_pixel_capture_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic sync_out,
    output logic rise,
    output logic fall
);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_prev;

    // Shift the asynchronous input through the synchroniser and remember the last synced value
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync <= '0;
            r_prev <= 1'b0;
        end else begin
            r_sync[0] <= din;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                r_sync[i] <= r_sync[i-1];
            end
            r_prev <= r_sync[SYNC_STAGES-1];
        end
    end

    assign sync_out = r_sync[SYNC_STAGES-1];
    assign rise     = r_sync[SYNC_STAGES-1] & ~r_prev;
    assign fall     = ~r_sync[SYNC_STAGES-1] & r_prev;

endmodule
`default_nettype wire

// File: rtl/cam_pixel_capture.sv
`default_nettype none
// ============================================================================
// Module   : cam_pixel_capture
// Brief    : Captures an 8-bit camera byte stream (two bytes per RGB565 pixel)
//            into frame-buffer writes on the system clock.
// Config   : CAM_DECIMATE_EN - when defined, the camera delivers a frame of
//            twice the stored size in each direction and only even pixels of
//            even lines are written.
// Revision : 1.0 - initial release
// ============================================================================
module cam_pixel_capture
    import cam_pixel_capture_pkg::*;
#(
    parameter int H_ACTIVE    = DEF_H_ACTIVE,
    parameter int V_ACTIVE    = DEF_V_ACTIVE,
    parameter int SYNC_STAGES = 2
) (
    input  logic                 MAX10_CLK1_50,
    input  logic                 rst_n,
    input  logic                 c_PCLK,
    input  logic                 c_HREF,
    input  logic                 c_VSYNC,
    input  logic [7:0]           c_DOUT,
    input  logic                 enable,
    output logic [15:0]          w_data,
    output logic                 w_en,
    output logic [FB_ADDR_W-1:0] w_index,
    output logic                 frame_start,
    output logic                 frame_done,
    output logic                 overflow
);

    localparam logic [FB_ADDR_W-1:0] c_PIX_TOTAL = FB_ADDR_W'(H_ACTIVE * V_ACTIVE);

    // ------------------------------------------------------------------
    // Input synchronisation: strobes and data share the same depth so a
    // byte lines up with the PCLK edge that qualifies it.
    // ------------------------------------------------------------------
    logic w_pclk_sync, w_pclk_rise, w_pclk_fall;
    logic w_href_sync, w_href_rise, w_href_fall;
    logic w_vs_sync,   w_vs_rise,   w_vs_fall;

    cam_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_pclk (
        .clk      (MAX10_CLK1_50),
        .rst_n    (rst_n),
        .din      (c_PCLK),
        .sync_out (w_pclk_sync),
        .rise     (w_pclk_rise),
        .fall     (w_pclk_fall)
    );

    cam_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_href (
        .clk      (MAX10_CLK1_50),
        .rst_n    (rst_n),
        .din      (c_HREF),
        .sync_out (w_href_sync),
        .rise     (w_href_rise),
        .fall     (w_href_fall)
    );

    cam_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_vsync (
        .clk      (MAX10_CLK1_50),
        .rst_n    (rst_n),
        .din      (c_VSYNC),
        .sync_out (w_vs_sync),
        .rise     (w_vs_rise),
        .fall     (w_vs_fall)
    );

    // Edge-detector outputs this controller has no use for
    logic w_unused_edges;
    assign w_unused_edges = w_pclk_sync ^ w_pclk_fall ^ w_href_rise ^ w_vs_sync;

    logic [7:0] r_dout_sync [SYNC_STAGES];
    logic [7:0] w_byte;

    // Byte-bus synchroniser, same depth as the strobe synchronisers
    always_ff @(posedge MAX10_CLK1_50 or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                r_dout_sync[i] <= '0;
            end
        end else begin
            r_dout_sync[0] <= c_DOUT;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                r_dout_sync[i] <= r_dout_sync[i-1];
            end
        end
    end

    assign w_byte = r_dout_sync[SYNC_STAGES-1];

    // ------------------------------------------------------------------
    // Capture controller
    // ------------------------------------------------------------------
    cap_state_t r_state, w_state_nxt;
    logic       w_start;
    logic       w_done;
    logic       w_take;

    // State register
    always_ff @(posedge MAX10_CLK1_50 or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state and per-cycle controls; VSYNC rise outranks a coincident PCLK edge
    always_comb begin
        w_state_nxt = r_state;
        w_start     = 1'b0;
        w_done      = 1'b0;
        w_take      = 1'b0;
        if (!enable) begin
            w_state_nxt = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    w_state_nxt = ST_WAIT_VSYNC;
                end
                ST_WAIT_VSYNC: begin
                    if (w_vs_fall) begin
                        w_state_nxt = ST_CAPTURE;
                        w_start     = 1'b1;
                    end
                end
                ST_CAPTURE: begin
                    if (w_vs_rise) begin
                        w_state_nxt = ST_WAIT_VSYNC;
                        w_done      = 1'b1;
                    end else if (w_pclk_rise && w_href_sync) begin
                        w_take = 1'b1;
                    end
                end
                default: begin
                    w_state_nxt = ST_IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Pixel assembly and write-address datapath
    // ------------------------------------------------------------------
    rgb565_t r_pix;
    logic    r_phase;
    logic    r_wr_pend;
    logic    w_keep;

`ifdef CAM_DECIMATE_EN
    logic r_line_odd;
    logic r_pix_odd;
    assign w_keep = ~r_line_odd & ~r_pix_odd;
`else
    assign w_keep = 1'b1;
`endif

    // Byte pairing, write strobe, address advance and overflow tracking
    always_ff @(posedge MAX10_CLK1_50 or negedge rst_n) begin
        if (!rst_n) begin
            r_pix       <= '0;
            r_phase     <= 1'b0;
            r_wr_pend   <= 1'b0;
            w_en        <= 1'b0;
            w_index     <= '0;
            frame_start <= 1'b0;
            frame_done  <= 1'b0;
            overflow    <= 1'b0;
`ifdef CAM_DECIMATE_EN
            r_line_odd  <= 1'b0;
            r_pix_odd   <= 1'b0;
`endif
        end else begin
            frame_start <= w_start;
            frame_done  <= w_done;
            // A completed pixel is dropped if capture was disabled meanwhile
            w_en        <= r_wr_pend & enable;
            r_wr_pend   <= 1'b0;

            if (w_start) begin
                w_index    <= '0;
                r_phase    <= 1'b0;
                overflow   <= 1'b0;
`ifdef CAM_DECIMATE_EN
                r_line_odd <= 1'b0;
                r_pix_odd  <= 1'b0;
`endif
            end else begin
                // Address advances after its pixel was presented, saturating at the frame size
                if (w_en && (w_index < c_PIX_TOTAL)) begin
                    w_index <= w_index + FB_ADDR_W'(1);
                end

                if (w_href_fall) begin
                    // A lone first byte at line end is abandoned
                    r_phase <= 1'b0;
`ifdef CAM_DECIMATE_EN
                    r_line_odd <= ~r_line_odd;
                    r_pix_odd  <= 1'b0;
`endif
                end else if (w_take) begin
                    if (!r_phase) begin
                        r_pix[15:8] <= w_byte;
                        r_phase     <= 1'b1;
                    end else begin
                        r_pix[7:0]  <= w_byte;
                        r_phase     <= 1'b0;
`ifdef CAM_DECIMATE_EN
                        r_pix_odd   <= ~r_pix_odd;
`endif
                        if (w_keep) begin
                            if (w_index >= c_PIX_TOTAL) begin
                                overflow <= 1'b1;
                            end else begin
                                r_wr_pend <= 1'b1;
                            end
                        end
                    end
                end
            end
        end
    end

    assign w_data = r_pix;

endmodule
`default_nettype wire

// File: tb/tb_cam_pixel_capture.sv
`default_nettype none
// ============================================================================
// Module   : tb_cam_pixel_capture
// Brief    : Self-checking bench for cam_pixel_capture on a reduced 8x4 frame.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cam_pixel_capture;

    localparam int H     = 8;
    localparam int V     = 4;
    localparam int S     = 2;
    localparam int TOTAL = H * V;

    logic        MAX10_CLK1_50 = 1'b0;
    logic        rst_n         = 1'b0;
    logic        c_PCLK        = 1'b0;
    logic        c_HREF        = 1'b0;
    logic        c_VSYNC       = 1'b0;
    logic [7:0]  c_DOUT        = 8'h00;
    logic        enable        = 1'b0;
    logic [15:0] w_data;
    logic        w_en;
    logic [16:0] w_index;
    logic        frame_start;
    logic        frame_done;
    logic        overflow;

    cam_pixel_capture #(
        .H_ACTIVE    (H),
        .V_ACTIVE    (V),
        .SYNC_STAGES (S)
    ) dut (
        .MAX10_CLK1_50 (MAX10_CLK1_50),
        .rst_n         (rst_n),
        .c_PCLK        (c_PCLK),
        .c_HREF        (c_HREF),
        .c_VSYNC       (c_VSYNC),
        .c_DOUT        (c_DOUT),
        .enable        (enable),
        .w_data        (w_data),
        .w_en          (w_en),
        .w_index       (w_index),
        .frame_start   (frame_start),
        .frame_done    (frame_done),
        .overflow      (overflow)
    );

    always #10 MAX10_CLK1_50 = ~MAX10_CLK1_50;

    typedef struct packed {
        logic [15:0] d;
        logic [16:0] i;
    } wr_t;

    typedef struct {
        int          nbytes;
        logic [63:0] bytes;
        int          exp_writes;
        logic [15:0] exp_first;
    } vec_t;

    wr_t        act_q[$];
    wr_t        exp_q[$];
    logic [7:0] lbuf[$];
    int         n_fs = 0;
    int         n_fd = 0;
    int         m_idx = 0;
    logic       m_ovf = 1'b0;
    int         total = 0;
    int         bad   = 0;

    // Observe the write port and pulses half a cycle after each active edge
    always @(negedge MAX10_CLK1_50) begin
        if (rst_n) begin
            if (w_en)        act_q.push_back({w_data, w_index});
            if (frame_start) n_fs++;
            if (frame_done)  n_fd++;
        end
    end

    initial begin
        #(20 * 40000);
        $display("FAIL watchdog: got no completion expected finish within 40000 cycles");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge MAX10_CLK1_50);
    endtask

    // One camera PCLK period (4 system clocks) carrying a byte
    task automatic pclk_cycle(input logic [7:0] b, input logic h);
        c_DOUT = b;
        c_HREF = h;
        c_PCLK = 1'b1;
        tick(2);
        c_PCLK = 1'b0;
        tick(2);
    endtask

    // Send lbuf as one HREF line; optionally extend the reference model
    task automatic send_line(input bit model);
        foreach (lbuf[k]) pclk_cycle(lbuf[k], 1'b1);
        pclk_cycle(8'h00, 1'b0);
        tick(2);
        if (model) begin
            for (int k = 0; k + 1 < lbuf.size(); k += 2) begin
                if (m_idx < TOTAL) begin
                    exp_q.push_back({lbuf[k], lbuf[k+1], 17'(m_idx)});
                    m_idx++;
                end else begin
                    m_ovf = 1'b1;
                end
            end
        end
    endtask

    task automatic rand_line(input int nbytes);
        lbuf = {};
        repeat (nbytes) lbuf.push_back(8'($urandom));
    endtask

    task automatic frame_begin();
        c_VSYNC = 1'b1;
        tick(6);
        c_VSYNC = 1'b0;
        tick(6);
        m_idx = 0;
        m_ovf = 1'b0;
    endtask

    task automatic frame_end();
        c_VSYNC = 1'b1;
        tick(6);
    endtask

    task automatic compare_writes(input string name);
        int n;
        check({name, " count"}, act_q.size(), exp_q.size());
        n = (act_q.size() < exp_q.size()) ? act_q.size() : exp_q.size();
        for (int k = 0; k < n; k++) begin
            check($sformatf("%s data[%0d]", name, k), {16'h0, act_q[k].d}, {16'h0, exp_q[k].d});
            check($sformatf("%s idx[%0d]", name, k), {15'h0, act_q[k].i}, {15'h0, exp_q[k].i});
        end
        act_q.delete();
        exp_q.delete();
    endtask

    initial begin
        vec_t        vt[5];
        logic [63:0] tmp;
        int          base;
        int          exp_idx;
        int          fs0;
        int          fd0;
        int          lat;

        vt[0] = '{8, 64'hF800_07E0_001F_FFFF, 4, 16'hF800};
        vt[1] = '{3, 64'h1234_5600_0000_0000, 1, 16'h1234};
        vt[2] = '{2, 64'hABCD_0000_0000_0000, 1, 16'hABCD};
        vt[3] = '{1, 64'h7700_0000_0000_0000, 0, 16'h0000};
        vt[4] = '{6, 64'h0102_0304_0506_0000, 3, 16'h0102};

        // Reset state
        tick(3);
        check("rst w_en",        {31'h0, w_en},        0);
        check("rst w_index",     {15'h0, w_index},     0);
        check("rst w_data",      {16'h0, w_data},      0);
        check("rst overflow",    {31'h0, overflow},    0);
        check("rst frame_start", {31'h0, frame_start}, 0);
        check("rst frame_done",  {31'h0, frame_done},  0);
        rst_n = 1'b1;
        tick(2);
        enable = 1'b1;
        tick(2);

        // Directed line table within one frame
        fs0 = n_fs;
        frame_begin();
        check("table frame_start", n_fs - fs0, 1);
        exp_idx = 0;
        for (int t = 0; t < 5; t++) begin
            base = act_q.size();
            tmp  = vt[t].bytes;
            lbuf = {};
            for (int k = 0; k < vt[t].nbytes; k++) lbuf.push_back(tmp[63-8*k -: 8]);
            send_line(1'b1);
            check($sformatf("vec%0d writes", t), act_q.size() - base, vt[t].exp_writes);
            if (vt[t].exp_writes > 0 && act_q.size() > base) begin
                check($sformatf("vec%0d first data", t), {16'h0, act_q[base].d}, {16'h0, vt[t].exp_first});
                check($sformatf("vec%0d first idx", t), {15'h0, act_q[base].i}, exp_idx);
            end
            exp_idx += vt[t].exp_writes;
        end
        fd0 = n_fd;
        frame_end();
        check("table frame_done", n_fd - fd0, 1);
        check("table overflow", {31'h0, overflow}, 0);
        compare_writes("table");

        // Latency from second-byte PCLK rise at the pins to w_en
        frame_begin();
        pclk_cycle(8'hAB, 1'b1);
        c_DOUT = 8'hCD;
        c_PCLK = 1'b1;
        lat = 0;
        for (int k = 1; k <= 12; k++) begin
            @(negedge MAX10_CLK1_50);
            if (w_en && lat == 0) lat = k;
            if (k == 2) c_PCLK = 1'b0;
        end
        check("latency cycles", lat, S + 2);
        pclk_cycle(8'h00, 1'b0);
        exp_q.push_back({16'hABCD, 17'd0});
        frame_end();
        compare_writes("latency");

        // Random frames with ragged line lengths
        for (int f = 0; f < 3; f++) begin
            frame_begin();
            for (int l = 0; l < int'($urandom_range(1, V + 1)); l++) begin
                rand_line(int'($urandom_range(0, 2 * H + 1)));
                send_line(1'b1);
            end
            fd0 = n_fd;
            frame_end();
            check($sformatf("rand%0d frame_done", f), n_fd - fd0, 1);
            check($sformatf("rand%0d overflow", f), {31'h0, overflow}, {31'h0, m_ovf});
            compare_writes($sformatf("rand%0d", f));
        end

        // Exactly full frame
        frame_begin();
        for (int l = 0; l < V; l++) begin
            rand_line(2 * H);
            send_line(1'b1);
        end
        fd0 = n_fd;
        frame_end();
        check("full frame_done", n_fd - fd0, 1);
        check("full overflow", {31'h0, overflow}, 0);
        if (act_q.size() > 0) check("full last idx", {15'h0, act_q[act_q.size()-1].i}, TOTAL - 1);
        compare_writes("full");

        // One pixel too many
        frame_begin();
        for (int l = 0; l < V; l++) begin
            rand_line(2 * H);
            send_line(1'b1);
        end
        rand_line(2);
        send_line(1'b1);
        frame_end();
        check("ovf overflow", {31'h0, overflow}, {31'h0, m_ovf});
        compare_writes("ovf");
        fs0 = n_fs;
        frame_begin();
        check("ovf next frame_start", n_fs - fs0, 1);
        check("ovf cleared", {31'h0, overflow}, 0);
        frame_end();

        // Enable drops while a pixel's second byte is in flight
        act_q.delete();
        frame_begin();
        pclk_cycle(8'h11, 1'b1);
        pclk_cycle(8'h22, 1'b1);
        pclk_cycle(8'h33, 1'b1);
        c_DOUT = 8'h44;
        c_PCLK = 1'b1;
        tick(3);
        enable = 1'b0;
        tick(1);
        c_PCLK = 1'b0;
        tick(2);
        pclk_cycle(8'h55, 1'b1);
        pclk_cycle(8'h66, 1'b1);
        pclk_cycle(8'h00, 1'b0);
        check("en drop writes", act_q.size(), 1);
        if (act_q.size() > 0) check("en drop data", {16'h0, act_q[0].d}, 32'h1122);
        act_q.delete();
        enable = 1'b1;
        tick(2);
        rand_line(4);
        send_line(1'b0);
        check("re-enable no vsync writes", act_q.size(), 0);
        act_q.delete();
        frame_begin();
        rand_line(4);
        send_line(1'b1);
        frame_end();
        compare_writes("re-enable");

        // Reset mid-frame
        frame_begin();
        rand_line(4);
        send_line(1'b0);
        rst_n = 1'b0;
        tick(2);
        check("midrst w_index", {15'h0, w_index}, 0);
        check("midrst w_en", {31'h0, w_en}, 0);
        rst_n = 1'b1;
        tick(2);
        act_q.delete();
        rand_line(4);
        send_line(1'b0);
        check("midrst no writes", act_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
